// File: rtl/imem_loader.sv
// Instruction memory loader: collects a byte stream into 32-bit words and
// writes them to instruction memory while the CPU front end is held.
module imem_loader #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t      state_reg;
  logic [31:0] base_reg;
  logic [15:0] count_reg;
  logic [15:0] k_reg;
  logic [1:0]  byte_idx_reg;
  logic [31:0] word_reg;
  logic [31:0] word_next;
  logic [1:0]  lane_sel;
  logic        accept;

  // byte_ready is registered and high only in COLLECT, so it gates acceptance
  assign accept   = byte_valid & byte_ready;
  assign lane_sel = BIG_ENDIAN ? (2'd3 - byte_idx_reg) : byte_idx_reg;

  // Drop the incoming byte into its lane; other lanes keep the partial word
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (lane_sel == 2'(gi)) ? byte_data : word_reg[8*gi +: 8];
    end
  endgenerate

  // Load sequencer with all outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      count_reg    <= '0;
      k_reg        <= '0;
      byte_idx_reg <= '0;
      word_reg     <= '0;
      byte_ready   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (base_addr[1:0] != 2'b00) begin
              // Misaligned base: reject without latching anything
              err <= 1'b1;
            end else if (word_count == 16'd0) begin
              state_reg <= DONE;
              busy      <= 1'b1;
              cpu_hold  <= 1'b1;
              done      <= 1'b1;
            end else begin
              state_reg    <= COLLECT;
              base_reg     <= base_addr;
              count_reg    <= word_count;
              k_reg        <= '0;
              byte_idx_reg <= '0;
              word_reg     <= '0;
              byte_ready   <= 1'b1;
              busy         <= 1'b1;
              cpu_hold     <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            word_reg     <= word_next;
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              // Fourth byte: present the complete word for one write cycle
              state_reg  <= WRITE;
              byte_ready <= 1'b0;
              imem_we    <= 1'b1;
              imem_addr  <= base_reg + {14'd0, k_reg, 2'b00};
              imem_wdata <= word_next;
            end
          end
        end
        WRITE: begin
          if (k_reg == count_reg - 16'd1) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else begin
            k_reg      <= k_reg + 16'd1;
            state_reg  <= COLLECT;
            byte_ready <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          cpu_hold  <= 1'b0;
        end
        default: begin
          state_reg  <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a big-endian and a little-endian instance
// share the byte stream; directed loads push expected events, a negedge
// monitor pops and compares every write, done and err the DUTs present.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_be = 1'b0;
  logic        start_le = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;

  logic        byte_ready_be, imem_we_be, cpu_hold_be, busy_be, done_be, err_be;
  logic [31:0] imem_addr_be, imem_wdata_be;
  logic        byte_ready_le, imem_we_le, cpu_hold_le, busy_le, done_le, err_le;
  logic [31:0] imem_addr_le, imem_wdata_le;

  imem_loader #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .start(start_be), .base_addr(base_addr),
    .word_count(word_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready_be), .imem_we(imem_we_be), .imem_addr(imem_addr_be),
    .imem_wdata(imem_wdata_be), .cpu_hold(cpu_hold_be), .busy(busy_be),
    .done(done_be), .err(err_be)
  );

  imem_loader #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .start(start_le), .base_addr(base_addr),
    .word_count(word_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready_le), .imem_we(imem_we_le), .imem_addr(imem_addr_le),
    .imem_wdata(imem_wdata_le), .cpu_hold(cpu_hold_le), .busy(busy_le),
    .done(done_le), .err(err_le)
  );

  always #5 clk = ~clk;

  // kind: 0 = write, 1 = done, 2 = err; inst: 0 = big-endian, 1 = little-endian
  // gap: required cycles since the previous event (0 = don't care)
  typedef struct {
    int          kind;
    int          inst;
    logic [31:0] addr;
    logic [31:0] data;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  bit   use_le = 1'b0;

  always @(posedge clk) cyc++;

  task automatic push(input int kind, input int inst, input logic [31:0] a,
                      input logic [31:0] d, input int gap);
    exp_t e;
    e.kind = kind; e.inst = inst; e.addr = a; e.data = d; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(input int kind, input int inst, input logic [31:0] a,
                         input logic [31:0] d);
    exp_t e;
    bit ok;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d inst=%0d addr=%h data=%h expected none",
               kind, inst, a, d);
    end else begin
      e = q.pop_front();
      ok = (e.kind == kind) && (e.inst == inst) &&
           (kind != 0 || (e.addr == a && e.data == d)) &&
           (e.gap == 0 || (cyc - last_cyc) == e.gap);
      if (!ok) begin
        n_bad++;
        $display("FAIL event: got kind=%0d inst=%0d addr=%h data=%h gap=%0d expected kind=%0d inst=%0d addr=%h data=%h gap=%0d",
                 kind, inst, a, d, cyc - last_cyc, e.kind, e.inst, e.addr, e.data, e.gap);
      end else begin
        $display("event kind=%0d inst=%0d addr=%h data=%h ok", kind, inst, a, d);
      end
    end
    last_cyc = cyc;
  endtask

  // Monitor: sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (imem_we_be) observe(0, 0, imem_addr_be, imem_wdata_be);
    if (done_be)    observe(1, 0, 32'd0, 32'd0);
    if (err_be)     observe(2, 0, 32'd0, 32'd0);
    if (imem_we_le) observe(0, 1, imem_addr_le, imem_wdata_le);
    if (done_le)    observe(1, 1, 32'd0, 32'd0);
    if (err_le)     observe(2, 1, 32'd0, 32'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [15:0] cnt);
    base_addr  = base;
    word_count = cnt;
    if (use_le) start_le = 1'b1; else start_be = 1'b1;
    tick();
    start_be = 1'b0;
    start_le = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit sent;
    sent = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50 && !sent; i++) begin
      sent = use_le ? byte_ready_le : byte_ready_be;
      tick();
    end
    byte_valid = 1'b0;
    if (!sent) check("byte_accept_timeout", 80'd0, 80'd1);
  endtask

  task automatic drain;
    for (int i = 0; i < 300 && q.size() != 0; i++) tick();
    repeat (3) tick();
    check("queue_drained", 80'(q.size()), 80'd0);
  endtask

  function automatic logic [79:0] outs_be;
    return {byte_ready_be, imem_we_be, imem_addr_be, imem_wdata_be,
            cpu_hold_be, busy_be, done_be, err_be};
  endfunction

  function automatic logic [79:0] outs_le;
    return {byte_ready_le, imem_we_le, imem_addr_le, imem_wdata_le,
            cpu_hold_le, busy_le, done_le, err_le};
  endfunction

  initial begin
    logic [7:0] t1 [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h24, 8'h09, 8'h00, 8'h07};
    logic [7:0] t2 [4] = '{8'h05, 8'h00, 8'h08, 8'h20};
    logic [7:0] t4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] t5 [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] t6 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    bit ready_ok;

    // Reset state
    #3;
    check("reset_outputs_be", outs_be(), 80'd0);
    check("reset_outputs_le", outs_le(), 80'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Two big-endian words back to back, done one cycle after second write
    push(0, 0, 32'h40, 32'h20080005, 0);
    push(0, 0, 32'h44, 32'h24090007, 0);
    push(1, 0, 32'h0, 32'h0, 1);
    pulse_start(32'h40, 16'd2);
    check("busy_after_start", 80'(busy_be), 80'd1);
    check("hold_after_start", 80'(cpu_hold_be), 80'd1);
    foreach (t1[i]) send_byte(t1[i]);
    drain();
    check("hold_released", 80'(cpu_hold_be), 80'd0);
    check("busy_released", 80'(busy_be), 80'd0);

    // Little-endian lane order
    use_le = 1'b1;
    push(0, 1, 32'h100, 32'h20080005, 0);
    push(1, 1, 32'h0, 32'h0, 1);
    pulse_start(32'h100, 16'd1);
    foreach (t2[i]) send_byte(t2[i]);
    drain();
    use_le = 1'b0;

    // Misaligned base rejected
    push(2, 0, 32'h0, 32'h0, 0);
    pulse_start(32'h42, 16'd1);
    check("misaligned_busy", 80'(busy_be), 80'd0);
    drain();

    // Zero-length load goes straight to done
    push(1, 0, 32'h0, 32'h0, 0);
    pulse_start(32'h80, 16'd0);
    check("zero_count_busy", 80'(busy_be), 80'd1);
    drain();

    // Gapped byte stream; byte_ready must stay high through the gaps
    push(0, 0, 32'h200, 32'h11223344, 0);
    push(1, 0, 32'h0, 32'h0, 1);
    pulse_start(32'h200, 16'd1);
    ready_ok = 1'b1;
    foreach (t4[i]) begin
      send_byte(t4[i]);
      if (i < 3) begin
        repeat (3) begin
          if (!byte_ready_be) ready_ok = 1'b0;
          tick();
        end
      end
    end
    check("ready_held_in_gaps", 80'(ready_ok), 80'd1);
    drain();

    // Reset mid-load: no write, no done, then a fresh load
    pulse_start(32'h300, 16'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs_be(), 80'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push(0, 0, 32'h400, 32'hDEADBEEF, 0);
    push(1, 0, 32'h0, 32'h0, 1);
    pulse_start(32'h400, 16'd1);
    foreach (t5[i]) send_byte(t5[i]);
    drain();

    // Address wrap with an ignored start in the middle of the load
    push(0, 0, 32'hFFFFFFFC, 32'h01020304, 0);
    push(0, 0, 32'h00000000, 32'h05060708, 0);
    push(1, 0, 32'h0, 32'h0, 1);
    pulse_start(32'hFFFFFFFC, 16'd2);
    send_byte(t6[0]);
    send_byte(t6[1]);
    pulse_start(32'h500, 16'd1);
    check("busy_after_ignored_start", 80'(busy_be), 80'd1);
    for (int i = 2; i < 8; i++) send_byte(t6[i]);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 BIG_ENDIAN, 1, first received byte of each word lands in bits 31:24 when 1; bits 7:0 when 0.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  single-cycle request to begin a load; sampled in IDLE only.
REQ-005 base_addr  in  32  byte address of first instruction word; sampled with start.
REQ-006 word_count  in  16  number of 32-bit words to load; sampled with start.
REQ-007 byte_valid  in  1  source presents a byte on byte_data.
REQ-008 byte_data  in  8  instruction byte stream.
REQ-009 byte_ready  out  1  loader accepts a byte this cycle.
REQ-010 imem_we  out  1  instruction memory write strobe.
REQ-011 imem_addr  out  32  instruction memory byte address.
REQ-012 imem_wdata  out  32  assembled instruction word.
REQ-013 cpu_hold  out  1  freezes PC and IF/ID register while asserted.
REQ-014 busy  out  1  load in progress.
REQ-015 done  out  1  one-cycle pulse at load completion.
REQ-016 err  out  1  one-cycle pulse on rejected start.

Function
REQ-017 FSM states IDLE, COLLECT, WRITE, DONE; all outputs registered.
REQ-018 IDLE: start with base_addr[1:0]==0 and word_count!=0 -> latch base_addr, word_count, clear word index k and byte index -> COLLECT.
REQ-019 IDLE: start with word_count==0 and aligned base -> DONE directly; no imem write.
REQ-020 IDLE: start with base_addr[1:0]!=0 -> err=1 next cycle, remain IDLE, nothing latched.
REQ-021 start while not IDLE is ignored; no err, no effect on load in progress.
REQ-022 COLLECT: byte_ready=1; byte accepted only when byte_valid&byte_ready in same cycle; byte index 0..3 selects byte lane per BIG_ENDIAN.
REQ-023 byte_valid low in COLLECT: hold state, partial word retained indefinitely.
REQ-024 Fourth accepted byte -> WRITE on next edge; byte index returns to 0.
REQ-025 WRITE: exactly one cycle, imem_we=1, imem_addr=base+4*k (modulo 2^32), imem_wdata=assembled word, byte_ready=0.
REQ-026 WRITE exit: k==word_count-1 -> DONE; else k+1 -> COLLECT.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 busy=1 and cpu_hold=1 in COLLECT, WRITE, DONE; 0 in IDLE.
REQ-029 imem_we=0, byte_ready=0 in IDLE and DONE.
REQ-030 Latency: last byte accepted at edge N -> imem_we high cycle N+1 -> done high cycle N+2 (final word).
REQ-031 Address wrap past 0xFFFFFFFC continues at 0x00000000, no error.
REQ-032 Maximum load 65535 words; k is 16 bits.

Reset
REQ-033 rst_n low: immediately IDLE, k=0, byte index=0, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, busy=0, done=0, err=0.
REQ-034 Reset mid-load discards partial word; no further imem write; no done pulse.
REQ-035 After rst_n release, first start accepted no earlier than first rising edge.

Verification
REQ-036 base=0x40, count=2, bytes 20 08 00 05 24 09 00 07 back-to-back -> writes 0x20080005@0x40, 0x24090007@0x44, done one cycle after second write, cpu_hold low after done.
REQ-037 BIG_ENDIAN=0, count=1, bytes 05 00 08 20 -> write 0x20080005@base.
REQ-038 base=0x42, count=1, start -> err pulse one cycle, busy stays 0, no imem_we.
REQ-039 count=0, start -> done pulse, zero writes; byte_valid gaps of 3 cycles between bytes in a count=1 load -> single correct write, byte_ready held high throughout COLLECT.
REQ-040 rst_n low after 2 bytes of word 1 -> all outputs zero asynchronously, no write; new load after release writes correct word at its own base.
REQ-041 base=0xFFFFFFFC, count=2 -> writes at 0xFFFFFFFC then 0x00000000; second start during load ignored.
